// File: rtl/shift_pkg.sv
// Shared shift-unit definitions: mode encodings and the layer-to-stage mapping.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  // Pipeline stage that evaluates shift layer k.
  function automatic int layer_stage(input int k, input int stages, input int layers);
    return (k * stages) / layers;
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One logarithmic shift layer: shifts or rotates by 2**K when en is set.
module shift_layer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  sh_mode_e         mode,
  input  logic             fill,
  output logic [WIDTH-1:0] y
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] sh;

  always_comb begin
    case (mode)
      SH_SLL:  sh = {data[WIDTH-S-1:0], {S{1'b0}}};
      SH_SRL:  sh = {{S{1'b0}}, data[WIDTH-1:S]};
      SH_SRA:  sh = {{S{fill}}, data[WIDTH-1:S]};
      default: sh = {data[S-1:0], data[WIDTH-1:S]};
    endcase
    y = en ? sh : data;
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready and a global stall.
// Optional out_zero/out_carry flags when SHIFT_FLAGS_EN is defined.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
`ifdef SHIFT_FLAGS_EN
  output logic                     out_zero,
  output logic                     out_carry,
`endif
  output logic [TAG_W-1:0]         out_tag
);

  localparam int L = $clog2(WIDTH);

  // Stage-s inputs; stage 0 comes straight from the ports.
  logic             vld_i   [STAGES];
  logic [WIDTH-1:0] data_i  [STAGES];
  logic [L-1:0]     shamt_i [STAGES];
  sh_mode_e         mode_i  [STAGES];
  logic             fill_i  [STAGES];
  logic [TAG_W-1:0] tag_i   [STAGES];
  logic [WIDTH-1:0] data_o  [STAGES];

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [TAG_W-1:0]  tag_q;

  logic [WIDTH-1:0] lay_in  [L];
  logic [WIDTH-1:0] lay_out [L];

  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = out_ready || !out_valid;
  assign out_y     = data_q[STAGES-1];
  assign out_tag   = tag_q;

`ifdef SHIFT_FLAGS_EN
  // Last bit shifted out depends only on the original operand; ROR's out_y msb is the same bit.
  logic [L-1:0] neg_sh, dec_sh;
  logic         carry_in;
  logic         carry_i [STAGES];
  logic         carry_q, zero_q;

  assign neg_sh = L'(0) - in_shamt;
  assign dec_sh = in_shamt - 1'b1;

  always_comb begin
    carry_in = 1'b0;
    if (in_shamt != '0)
      carry_in = (sh_mode_e'(in_mode) == SH_SLL) ? in_a[neg_sh] : in_a[dec_sh];
  end

  assign out_carry = carry_q;
  assign out_zero  = zero_q;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    if (s == 0) begin : g_in
      assign vld_i[0]   = in_valid;
      assign data_i[0]  = in_a;
      assign shamt_i[0] = in_shamt;
      assign mode_i[0]  = sh_mode_e'(in_mode);
      assign fill_i[0]  = in_a[WIDTH-1];
      assign tag_i[0]   = in_tag;
`ifdef SHIFT_FLAGS_EN
      assign carry_i[0] = carry_in;
`endif
    end else begin : g_ctl
      logic [L-1:0]     shamt_r;
      sh_mode_e         mode_r;
      logic             fill_r;
      logic [TAG_W-1:0] tag_r;
`ifdef SHIFT_FLAGS_EN
      logic             carry_r;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_r <= '0;
          mode_r  <= SH_SLL;
          fill_r  <= 1'b0;
          tag_r   <= '0;
`ifdef SHIFT_FLAGS_EN
          carry_r <= 1'b0;
`endif
        end else if (in_ready) begin
          shamt_r <= shamt_i[s-1];
          mode_r  <= mode_i[s-1];
          fill_r  <= fill_i[s-1];
          tag_r   <= tag_i[s-1];
`ifdef SHIFT_FLAGS_EN
          carry_r <= carry_i[s-1];
`endif
        end
      end
      assign vld_i[s]   = vld_q[s-1];
      assign data_i[s]  = data_q[s-1];
      assign shamt_i[s] = shamt_r;
      assign mode_i[s]  = mode_r;
      assign fill_i[s]  = fill_r;
      assign tag_i[s]   = tag_r;
`ifdef SHIFT_FLAGS_EN
      assign carry_i[s] = carry_r;
`endif
    end
  end

  // Layers chain within a stage; the first layer of a stage reads the stage input.
  for (genvar k = 0; k < L; k++) begin : g_lay
    localparam int ST  = layer_stage(k, STAGES, L);
    localparam int PST = (k == 0)     ? -1     : layer_stage(k - 1, STAGES, L);
    localparam int NST = (k == L - 1) ? STAGES : layer_stage(k + 1, STAGES, L);
    if (PST != ST) begin : g_first
      assign lay_in[k] = data_i[ST];
    end else begin : g_chain
      assign lay_in[k] = lay_out[k-1];
    end
    shift_layer #(.WIDTH(WIDTH), .K(k)) u_lay (
      .data (lay_in[k]),
      .en   (shamt_i[ST][k]),
      .mode (mode_i[ST]),
      .fill (fill_i[ST]),
      .y    (lay_out[k])
    );
    if (NST != ST) begin : g_last
      assign data_o[ST] = lay_out[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
`ifdef SHIFT_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else if (in_ready) begin
      tag_q <= tag_i[STAGES-1];
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]  <= vld_i[s];
        data_q[s] <= data_o[s];
      end
`ifdef SHIFT_FLAGS_EN
      carry_q <= carry_i[STAGES-1];
      zero_q  <= (data_o[STAGES-1] == '0);
`endif
    end
  end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined successor to the combinational 32-bit barrel shifter.
- Shifts a WIDTH-bit operand by a log2(WIDTH)-bit amount.
- Modes: SLL, SRL, SRA, plus a new ROR mode.
- Logarithmic shift layers are split across STAGES register stages.
- Valid/ready handshake on both sides, with full backpressure.
- Sits between the issue stage and writeback in the execute cluster; a TAG sideband carries the destination id alongside each operation.

Parameters:
- WIDTH, 32, operand width; must be a power of 2 and >= 8.
- STAGES, 2, number of pipeline register stages; legal range 1..log2(WIDTH).
- TAG_W, 5, sideband tag width, passed through unmodified.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an operation this cycle.
- in_a  in  WIDTH  operand.
- in_shamt  in  $clog2(WIDTH)  shift amount.
- in_mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_tag  out  TAG_W  tag matching out_y.

Behaviour:
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = out_ready || !out_valid. This is a global stall: the whole pipe freezes while the output is held.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 operation per cycle.
  - Results leave in order.
- Each stage holds a valid bit, a partial result, the remaining shamt bits, mode and tag.
  - Bubbles (valid=0) advance like data; they are not collapsed.
- Shift layers:
  - Layer k shifts by 2^k when shamt[k] is set, for k = 0..log2(WIDTH)-1.
  - Layer k is evaluated in stage floor(k*STAGES/log2(WIDTH)).
  - Layers are combinational within their stage, registered at the stage end.
- Arithmetic per mode:
  - SLL fills with zeros from the LSB side.
  - SRL fills with zeros from the MSB side.
  - SRA fills with the original in_a[WIDTH-1]. The sign bit is captured at input and carried down the pipe.
  - ROR rotates right; bits leaving the LSB re-enter at the MSB.
- shamt = 0: out_y = in_a for every mode.
- While stalled (out_valid && !out_ready):
  - All stage registers, including out_y and out_tag, hold their values.
  - in_ready = 0.
- Simultaneous input and output transfer in the same cycle is legal; the pipe advances by one.
- Reset:
  - While rst = 1: all valid bits clear, out_valid = 0, out_y = 0, out_tag = 0.
  - in_ready = 1 during and after reset, because it follows from out_valid = 0.
  - Reset mid-operation discards all in-flight operations. Nothing emerges after rst deasserts unless it was newly input.
- Input data fields are ignored when in_valid = 0.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- When defined, two extra ports are added, both aligned with out_y:
  - out_zero  out  1  result equals 0.
  - out_carry  out  1  last bit shifted out.
- out_carry definition:
  - SLL: in_a[WIDTH-shamt].
  - SRL and SRA: in_a[shamt-1].
  - ROR: out_y[WIDTH-1].
  - shamt = 0: 0 for all modes.
- Both flags reset to 0 and are held during a stall.
- When not defined, the ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package shift_pkg holds:
  - Mode constants SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROR = 2'b11, shared with the decoder's ALU definitions.
  - A localparam function for the layer-to-stage mapping.
- Sub-module shift_layer: one combinational layer, parametrised by WIDTH and K. It takes data, an enable bit, mode and fill bit, and returns the shifted data. It is instantiated log2(WIDTH) times through a generate loop.

Test Plan:
- SLL: WIDTH=32, a=0x8000_0001, shamt=1 -> after STAGES cycles out_y = 0x0000_0002; out_carry = 1 (if SHIFT_FLAGS_EN).
- SRL and SRA:
  - a=0x8000_0001, shamt=4, SRL -> 0x0800_0000, carry 0.
  - Same operand, SRA -> 0xF800_0000.
  - shamt=31, SRA -> 0xFFFF_FFFF.
- ROR and identity:
  - a=0x8000_0001, shamt=1, ROR -> 0xC000_0000, carry 1.
  - shamt=0 in every mode -> out_y = a, carry 0.
  - a=0 -> out_zero = 1.
- Backpressure: stream 8 back-to-back ops with tags 0..7, out_ready = 0 for 3 cycles mid-stream.
  - in_ready drops while stalled.
  - No loss or duplication; tags emerge in order 0..7.
  - out_y is stable throughout the stall.
- Reset mid-stream: assert rst for 1 cycle with STAGES ops in flight.
  - out_valid = 0 the next cycle and stays 0 until new input.
  - out_y = 0 and in_ready = 1.
- Parameter sweep: repeat the random-vs-model check (Verilog <<, >>, >>>, rotate reference) for WIDTH = 8, 32, 64 and STAGES = 1, 2, log2(WIDTH), with 10k random ops and random out_ready.
